useq_sequencer_p: RTL and testbench
===================================

// Module: useq_sequencer_p
// PURPOSE
//  Parametrised microprogram sequencer (Am2910 instruction set) for the control-store path.
//  Each cycle it selects the next microaddress Y from one of five sources: D, uPC, the loop counter, the stack top, or zero.
//  Adds over the fixed 12-bit/5-deep sequencer:
//  - width/depth parameters
//  - async reset
//  - stall input
//  - sticky stack overflow/underflow flags
// PARAMETERS
//  AW     12  microaddress width (Y, D, uPC, stack entries)
//  CW     AW  loop-counter width; counter loads D[CW-1:0], CW<=AW
//  DEPTH  5   stack entries, >=2; SPW=$clog2(DEPTH+1)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  hold    in   1      1 = freeze all state (Y and flags still evaluate combinationally)
//  i       in   4      instruction opcode
//  ccen_n  in   1      condition enable, active low
//  cc_n    in   1      condition code, active low
//  rld_n   in   1      counter load override, active low
//  ci      in   1      uPC incrementer carry-in
//  d       in   AW     direct/branch input
//  y       out  AW     next microaddress (combinational)
//  pl_n    out  1      low when i is not 2 and not 6
//  map_n   out  1      low when i==2
//  vect_n  out  1      low when i==6
//  full_n  out  1      low when sp==DEPTH
//  empty   out  1      high when sp==0
//  ovf     out  1      sticky: push attempted while full
//  udf     out  1      sticky: pop attempted while empty
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - uPC=0, cnt=0, sp=0, ovf=0, udf=0; stack contents=0.
//  - Outputs: full_n=1, empty=1.
//  Signals:
//  - pass = ~(ccen_n==0 & cc_n==1).
//  - rz = (cnt!=0).
//  - top = stk[sp-1]; top=0 when sp==0.
//  Opcode table (Y source; side effects):
//   0 JZ   : 0; sp<=0, ovf<=0, udf<=0, uPC<=0 (ci ignored).
//   1 CJS  : pass: D, push. fail: uPC.
//   2 JMAP : D.
//   3 CJP  : pass: D. fail: uPC.
//   4 PUSH : uPC; push; pass: cnt<=D.
//   5 JSRP : push; pass: D. fail: cnt (zero-extended).
//   6 CJV  : pass: D. fail: uPC.
//   7 JRP  : pass: D. fail: cnt.
//   8 RFCT : rz: top, decr. !rz: uPC, pop.
//   9 RPCT : rz: D, decr. !rz: uPC.
//  10 CRTN : pass: top, pop. fail: uPC.
//  11 CJPP : pass: D, pop. fail: uPC.
//  12 LDCT : uPC; cnt<=D.
//  13 LOOP : fail: top. pass: uPC, pop.
//  14 CONT : uPC.
//  15 TWB  : pass: uPC, pop.
//            fail&rz: top, decr.
//            fail&!rz: D, pop.
//  Register updates (per clock, when hold=0):
//  - uPC <= Y + ci, modulo 2^AW (except JZ).
//  - cnt: rld_n==0 loads D[CW-1:0] and overrides both decr and opcode loads.
//    Otherwise decr does cnt-1; decr only ever occurs when cnt!=0, so no wrap.
//  - push: stk[sp] <= uPC (the pre-update value), sp <= sp+1.
//    If sp==DEPTH: no write, sp unchanged, ovf<=1.
//  - pop: sp <= sp-1. If sp==0: sp stays 0, udf<=1.
//  - Push and pop are never both asserted; one opcode → at most one stack op per cycle.
//  - ovf/udf hold until reset or JZ; JZ clear wins over a same-cycle set.
//  - Stack contents at and above sp are don't-care; never driven to y.
//  Timing:
//  - Latency: y is combinational from i/cc/d/state.
//  - All state changes on the next rising clk edge.
//  - hold=1: uPC, cnt, sp, stack, ovf, udf all keep their values.
//  - rst_n deasserted mid-operation: state is already reset, and the first edge with rst_n=1 executes normally.
// TESTING
//  - Reset mid-run: sp=3, cnt=7, pull rst_n low between edges -> immediately sp=0, empty=1, ovf=udf=0, y with i=14 is 0.
//  - Loop: i=12, d=3, next i=8 (3 cycles) with sp=1, top=0x040 -> y=0x040, 0x040, 0x040, then cnt=0 -> y=uPC, sp=0.
//  - Overflow: DEPTH=5; 6 pushes via i=4 -> full_n=0 after the 5th; 6th leaves sp=5, top unchanged, ovf=1; then i=0 -> ovf=0, sp=0.
//  - Underflow: empty stack, i=10, pass -> y=0, sp=0, udf=1; hold=1 on the same cycle -> udf stays 0.
//  - Wrap/override: uPC at 2^AW-1, i=14, ci=1 -> uPC=0; i=15 fail rz with rld_n=0, d=9 -> cnt=9 (load beats decr).
//  - Params: AW=16, CW=8, DEPTH=8; CJS pass d=0xBEEF -> y=0xBEEF, stk[0]=old uPC; CRTN pass -> y=old uPC.

Source files
------------

// File: rtl/useq_sequencer_p.sv
// Microprogram sequencer implementing the Am2910 instruction set, with parametrised
// address/counter width and stack depth, a stall input and sticky stack error flags.
module useq_sequencer_p #(
  parameter int AW    = 12,
  parameter int CW    = AW,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic [3:0]    i,
  input  logic          ccen_n,
  input  logic          cc_n,
  input  logic          rld_n,
  input  logic          ci,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] y,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n,
  output logic          full_n,
  output logic          empty,
  output logic          ovf,
  output logic          udf
);

  localparam int SPW = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CJS  = 4'd1,
    OP_JMAP = 4'd2,
    OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,
    OP_JSRP = 4'd5,
    OP_CJV  = 4'd6,
    OP_JRP  = 4'd7,
    OP_RFCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_CRTN = 4'd10,
    OP_CJPP = 4'd11,
    OP_LDCT = 4'd12,
    OP_LOOP = 4'd13,
    OP_CONT = 4'd14,
    OP_TWB  = 4'd15
  } op_e;

  logic [AW-1:0]  upc_r;
  logic [CW-1:0]  cnt_r;
  logic [SPW-1:0] sp_r;
  logic [AW-1:0]  stk_r [DEPTH];
  logic           ovf_r;
  logic           udf_r;

  op_e            op_s;
  logic           pass_s;
  logic           rz_s;
  logic           full_s;
  logic           empty_s;
  logic [AW-1:0]  top_s;
  logic [AW-1:0]  cnt_ext_s;
  logic [AW-1:0]  y_s;
  logic           push_s;
  logic           pop_s;
  logic           decr_s;
  logic           ld_s;
  logic           jz_s;

  assign op_s      = op_e'(i);
  assign pass_s    = ~(~ccen_n & cc_n);
  assign rz_s      = (cnt_r != {CW{1'b0}});
  assign full_s    = (sp_r == SPW'(DEPTH));
  assign empty_s   = (sp_r == {SPW{1'b0}});
  assign cnt_ext_s = AW'(cnt_r);

  // Stack top as a compare-select over entries; reads zero on an empty stack.
  always_comb begin
    top_s = {AW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      top_s = (sp_r == SPW'(k + 1)) ? stk_r[k] : top_s;
    end
  end

  // Opcode decode: next-address source and the single stack/counter side effect.
  always_comb begin
    y_s    = upc_r;
    push_s = 1'b0;
    pop_s  = 1'b0;
    decr_s = 1'b0;
    ld_s   = 1'b0;
    jz_s   = 1'b0;
    case (op_s)
      OP_JZ: begin
        y_s  = {AW{1'b0}};
        jz_s = 1'b1;
      end
      OP_CJS: begin
        if (pass_s) begin
          y_s    = d;
          push_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_JMAP: y_s = d;
      OP_CJP, OP_CJV: begin
        if (pass_s) y_s = d;
        else        y_s = upc_r;
      end
      OP_PUSH: begin
        y_s    = upc_r;
        push_s = 1'b1;
        if (pass_s) ld_s = 1'b1;
        else        ld_s = 1'b0;
      end
      OP_JSRP: begin
        push_s = 1'b1;
        if (pass_s) y_s = d;
        else        y_s = cnt_ext_s;
      end
      OP_JRP: begin
        if (pass_s) y_s = d;
        else        y_s = cnt_ext_s;
      end
      OP_RFCT: begin
        if (rz_s) begin
          y_s    = top_s;
          decr_s = 1'b1;
        end else begin
          y_s   = upc_r;
          pop_s = 1'b1;
        end
      end
      OP_RPCT: begin
        if (rz_s) begin
          y_s    = d;
          decr_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_CRTN: begin
        if (pass_s) begin
          y_s   = top_s;
          pop_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_CJPP: begin
        if (pass_s) begin
          y_s   = d;
          pop_s = 1'b1;
        end else begin
          y_s = upc_r;
        end
      end
      OP_LDCT: begin
        y_s  = upc_r;
        ld_s = 1'b1;
      end
      OP_LOOP: begin
        if (pass_s) begin
          y_s   = upc_r;
          pop_s = 1'b1;
        end else begin
          y_s = top_s;
        end
      end
      OP_CONT: y_s = upc_r;
      OP_TWB: begin
        if (pass_s) begin
          y_s   = upc_r;
          pop_s = 1'b1;
        end else if (rz_s) begin
          y_s    = top_s;
          decr_s = 1'b1;
        end else begin
          y_s   = d;
          pop_s = 1'b1;
        end
      end
      default: y_s = upc_r;
    endcase
  end

  // uPC, loop counter, stack pointer and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_r <= {AW{1'b0}};
      cnt_r <= {CW{1'b0}};
      sp_r  <= {SPW{1'b0}};
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (!hold) begin
      upc_r <= jz_s ? {AW{1'b0}} : (y_s + AW'(ci));
      // An external reload beats both the opcode load and the decrement.
      if (!rld_n || ld_s) begin
        cnt_r <= d[CW-1:0];
      end else if (decr_s) begin
        cnt_r <= cnt_r - CW'(1'b1);
      end
      if (jz_s) begin
        sp_r  <= {SPW{1'b0}};
        ovf_r <= 1'b0;
        udf_r <= 1'b0;
      end else if (push_s) begin
        if (full_s) ovf_r <= 1'b1;
        else        sp_r  <= sp_r + SPW'(1'b1);
      end else if (pop_s) begin
        if (empty_s) udf_r <= 1'b1;
        else         sp_r  <= sp_r - SPW'(1'b1);
      end
    end
  end

  // Stack storage: a push saves the uPC value from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stk_r[k] <= {AW{1'b0}};
      end
    end else if (!hold && push_s && !full_s) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (sp_r == SPW'(k)) stk_r[k] <= upc_r;
      end
    end
  end

  assign y      = y_s;
  assign pl_n   = (i == 4'd2) | (i == 4'd6);
  assign map_n  = (i != 4'd2);
  assign vect_n = (i != 4'd6);
  assign full_n = ~full_s;
  assign empty  = empty_s;
  assign ovf    = ovf_r;
  assign udf    = udf_r;

endmodule

// File: tb/tb_useq_sequencer_p.sv
// Bench for useq_sequencer_p: vector table, directed corner sequences, a wide/deep
// parameter instance, and random stimulus against a queue-based reference model.
module tb_useq_sequencer_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hold, ccen_n, cc_n, rld_n, ci;
  logic [3:0]  i;
  logic [11:0] d, y;
  logic        pl_n, map_n, vect_n, full_n, empty, ovf, udf;

  logic        p_hold, p_ccen_n, p_cc_n, p_rld_n, p_ci;
  logic [3:0]  p_i;
  logic [15:0] p_d, p_y;
  logic        p_pl_n, p_map_n, p_vect_n, p_full_n, p_empty, p_ovf, p_udf;

  useq_sequencer_p dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .i(i), .ccen_n(ccen_n), .cc_n(cc_n),
    .rld_n(rld_n), .ci(ci), .d(d), .y(y), .pl_n(pl_n), .map_n(map_n),
    .vect_n(vect_n), .full_n(full_n), .empty(empty), .ovf(ovf), .udf(udf)
  );

  useq_sequencer_p #(.AW(16), .CW(8), .DEPTH(8)) dut_p (
    .clk(clk), .rst_n(rst_n), .hold(p_hold), .i(p_i), .ccen_n(p_ccen_n), .cc_n(p_cc_n),
    .rld_n(p_rld_n), .ci(p_ci), .d(p_d), .y(p_y), .pl_n(p_pl_n), .map_n(p_map_n),
    .vect_n(p_vect_n), .full_n(p_full_n), .empty(p_empty), .ovf(p_ovf), .udf(p_udf)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state (default instance: AW=CW=12, DEPTH=5)
  logic [11:0] m_upc, m_cnt;
  logic [11:0] m_stk[$];
  logic        m_ovf, m_udf;

  typedef struct {
    int          op;
    logic        cen;
    logic        ccn;
    logic        civ;
    logic [11:0] dv;
    int          ey;
    int          ee;
    int          eu;
  } vec_t;
  vec_t tbl[20];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_upc = 12'h000;
    m_cnt = 12'h000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // st: +1 push, -1 pop, 0 none
  task automatic model_eval(input int op, input logic cen, input logic ccn, input logic [11:0] dv,
                            output logic [11:0] yv, output int st, output logic dc,
                            output logic ld, output logic jz);
    logic pass, rz;
    logic [11:0] top;
    pass = !(!cen && ccn);
    rz   = (m_cnt != 12'h000);
    top  = (m_stk.size() == 0) ? 12'h000 : m_stk[$];
    yv = m_upc; st = 0; dc = 1'b0; ld = 1'b0; jz = 1'b0;
    case (op)
      0:  begin yv = 12'h000; jz = 1'b1; end
      1:  if (pass) begin yv = dv; st = 1; end
      2:  yv = dv;
      3, 6: if (pass) yv = dv;
      4:  begin st = 1; ld = pass; end
      5:  begin st = 1; yv = pass ? dv : m_cnt; end
      7:  yv = pass ? dv : m_cnt;
      8:  if (rz) begin yv = top; dc = 1'b1; end else st = -1;
      9:  if (rz) begin yv = dv; dc = 1'b1; end
      10: if (pass) begin yv = top; st = -1; end
      11: if (pass) begin yv = dv; st = -1; end
      12: ld = 1'b1;
      13: if (pass) st = -1; else yv = top;
      15: if (pass) st = -1;
          else if (rz) begin yv = top; dc = 1'b1; end
          else begin yv = dv; st = -1; end
      default: yv = m_upc;
    endcase
  endtask

  task automatic model_commit(input int op, input logic cen, input logic ccn, input logic rldv,
                              input logic civ, input logic [11:0] dv);
    logic [11:0] yv, old;
    int st;
    logic dc, ld, jz;
    model_eval(op, cen, ccn, dv, yv, st, dc, ld, jz);
    old = m_upc;
    if (jz) begin
      m_upc = 12'h000;
      m_stk.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_upc = yv + {11'h000, civ};
    end
    if (!rldv || ld) m_cnt = dv;
    else if (dc)     m_cnt = m_cnt - 12'h001;
    if (st == 1) begin
      if (m_stk.size() == 5) m_ovf = 1'b1;
      else                   m_stk.push_back(old);
    end else if (st == -1) begin
      if (m_stk.size() == 0) m_udf = 1'b1;
      else                   void'(m_stk.pop_back());
    end
  endtask

  // One cycle on the default instance: drive, compare with model (+optional constants), clock.
  task automatic step(input int op, input logic cen, input logic ccn, input logic rldv,
                      input logic civ, input logic [11:0] dv, input logic hv,
                      input int ey, input int ee, input int eu, input string tag);
    logic [11:0] my;
    int st;
    logic dc, ld, jz;
    @(negedge clk);
    i = 4'(op); ccen_n = cen; cc_n = ccn; rld_n = rldv; ci = civ; d = dv; hold = hv;
    #1;
    model_eval(op, cen, ccn, dv, my, st, dc, ld, jz);
    check({tag, " y"}, y, my);
    check({tag, " pl_n"}, pl_n, (op == 2 || op == 6) ? 1 : 0);
    check({tag, " map_n"}, map_n, (op != 2) ? 1 : 0);
    check({tag, " vect_n"}, vect_n, (op != 6) ? 1 : 0);
    check({tag, " full_n"}, full_n, (m_stk.size() != 5) ? 1 : 0);
    check({tag, " empty"}, empty, (m_stk.size() == 0) ? 1 : 0);
    check({tag, " ovf"}, ovf, m_ovf);
    check({tag, " udf"}, udf, m_udf);
    if (ey >= 0) check({tag, " y_const"}, y, ey);
    if (ee >= 0) check({tag, " empty_const"}, empty, ee);
    if (eu >= 0) check({tag, " udf_const"}, udf, eu);
    @(posedge clk);
    if (!hv) model_commit(op, cen, ccn, rldv, civ, dv);
  endtask

  // Registered flags just after the edge that step() ended on.
  task automatic chk_flags(input string tag, input int ee, input int ef, input int eo, input int eu);
    #2;
    if (ee >= 0) check({tag, " empty"}, empty, ee);
    if (ef >= 0) check({tag, " full_n"}, full_n, ef);
    if (eo >= 0) check({tag, " ovf"}, ovf, eo);
    if (eu >= 0) check({tag, " udf"}, udf, eu);
  endtask

  task automatic idle_inputs();
    i = 4'd14; hold = 1'b0; ccen_n = 1'b1; cc_n = 1'b1; rld_n = 1'b1; ci = 1'b0; d = 12'h000;
    p_i = 4'd14; p_hold = 1'b0; p_ccen_n = 1'b1; p_cc_n = 1'b1; p_rld_n = 1'b1; p_ci = 1'b0;
    p_d = 16'h0000;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, " rst y"}, y, 0);
    check({tag, " rst empty"}, empty, 1);
    check({tag, " rst full_n"}, full_n, 1);
    check({tag, " rst ovf"}, ovf, 0);
    check({tag, " rst udf"}, udf, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pdrive(input int op, input logic cen, input logic ccn, input logic civ,
                        input logic [15:0] dv);
    @(negedge clk);
    p_i = 4'(op); p_ccen_n = cen; p_cc_n = ccn; p_ci = civ; p_d = dv;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    //            op cen ccn ci  d        y      empty udf
    tbl[0]  = '{14, 1'b0, 1'b0, 1'b1, 12'h000, 'h000, 1, 0};
    tbl[1]  = '{ 3, 1'b0, 1'b0, 1'b1, 12'h100, 'h100, 1, 0};
    tbl[2]  = '{ 3, 1'b0, 1'b1, 1'b1, 12'h200, 'h101, 1, 0};
    tbl[3]  = '{ 1, 1'b0, 1'b0, 1'b1, 12'h300, 'h300, 1, 0};
    tbl[4]  = '{14, 1'b0, 1'b0, 1'b1, 12'h000, 'h301, 0, 0};
    tbl[5]  = '{10, 1'b0, 1'b0, 1'b1, 12'h000, 'h102, 0, 0};
    tbl[6]  = '{12, 1'b0, 1'b0, 1'b1, 12'h005, 'h103, 1, 0};
    tbl[7]  = '{ 7, 1'b0, 1'b1, 1'b1, 12'h7AA, 'h005, 1, 0};
    tbl[8]  = '{ 7, 1'b0, 1'b0, 1'b0, 12'h7AA, 'h7AA, 1, 0};
    tbl[9]  = '{ 9, 1'b0, 1'b0, 1'b1, 12'h050, 'h050, 1, 0};
    tbl[10] = '{ 2, 1'b0, 1'b0, 1'b1, 12'h0AB, 'h0AB, 1, 0};
    tbl[11] = '{ 6, 1'b0, 1'b0, 1'b1, 12'h0CD, 'h0CD, 1, 0};
    tbl[12] = '{ 5, 1'b0, 1'b1, 1'b1, 12'h111, 'h004, 1, 0};
    tbl[13] = '{11, 1'b0, 1'b0, 1'b1, 12'h222, 'h222, 0, 0};
    tbl[14] = '{ 0, 1'b0, 1'b0, 1'b1, 12'h000, 'h000, 1, 0};
    tbl[15] = '{ 8, 1'b0, 1'b0, 1'b1, 12'h000, 'h000, 1, 0};
    tbl[16] = '{13, 1'b0, 1'b0, 1'b1, 12'h000, 'h001, 1, 0};
    tbl[17] = '{14, 1'b0, 1'b0, 1'b1, 12'h000, 'h002, 1, 1};
    tbl[18] = '{ 0, 1'b0, 1'b0, 1'b1, 12'h000, 'h000, 1, 1};
    tbl[19] = '{14, 1'b0, 1'b0, 1'b0, 12'h000, 'h000, 1, 0};

    do_reset("init");
    for (int k = 0; k < 20; k++) begin
      step(tbl[k].op, tbl[k].cen, tbl[k].ccn, 1'b1, tbl[k].civ, tbl[k].dv, 1'b0,
           tbl[k].ey, tbl[k].ee, tbl[k].eu, $sformatf("tbl%0d", k));
    end

    // loop on counter with one saved address
    do_reset("loop");
    step(3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h03F, 1'b0, 'h03F, -1, -1, "loop_jmp");
    step(4, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 'h040, -1, -1, "loop_push");
    step(12, 1'b0, 1'b0, 1'b1, 1'b1, 12'h003, 1'b0, 'h041, -1, -1, "loop_ldct");
    for (int k = 0; k < 3; k++) step(8, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 'h040, 0, -1, "loop_rfct");
    step(8, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 'h041, 0, -1, "loop_exit");
    chk_flags("loop_end", 1, 1, 0, 0);

    // overflow then JZ clears
    do_reset("ovf");
    for (int k = 0; k < 6; k++) begin
      step(4, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, k, -1, -1, "ovf_push");
      if (k == 4) chk_flags("ovf_full", 0, 0, 0, -1);
      if (k == 5) chk_flags("ovf_set", 0, 0, 1, -1);
    end
    step(13, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 'h004, 0, -1, "ovf_top");
    step(0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 'h000, -1, -1, "ovf_jz");
    chk_flags("ovf_clr", 1, 1, 0, 0);

    // underflow, first stalled
    do_reset("udf");
    step(10, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 'h000, 1, 0, "udf_hold");
    chk_flags("udf_held", 1, 1, 0, 0);
    step(10, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 'h000, 1, 0, "udf_pop");
    chk_flags("udf_set", 1, 1, 0, 1);

    // uPC wrap and reload override
    do_reset("wrap");
    step(3, 1'b0, 1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0, 'hFFF, -1, -1, "wrap_jmp");
    step(14, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 'hFFF, -1, -1, "wrap_inc");
    step(14, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 'h000, -1, -1, "wrap_zero");
    step(12, 1'b0, 1'b0, 1'b1, 1'b0, 12'h002, 1'b0, 'h000, -1, -1, "wrap_ldct");
    step(15, 1'b0, 1'b1, 1'b0, 1'b0, 12'h009, 1'b0, 'h000, -1, -1, "wrap_twb");
    step(7, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 'h009, -1, -1, "wrap_cnt");

    // asynchronous reset between edges
    do_reset("mid");
    step(12, 1'b0, 1'b0, 1'b1, 1'b1, 12'h007, 1'b0, -1, -1, -1, "mid_ldct");
    for (int k = 0; k < 3; k++) step(4, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, -1, -1, -1, "mid_push");
    chk_flags("mid_sp3", 0, 1, 0, 0);
    #1;
    i = 4'd14; ci = 1'b0; rst_n = 1'b0;
    #1;
    check("mid_rst y", y, 0);
    check("mid_rst empty", empty, 1);
    check("mid_rst full_n", full_n, 1);
    check("mid_rst ovf", ovf, 0);
    check("mid_rst udf", udf, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(14, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 'h000, 1, -1, "mid_run0");
    step(14, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 'h001, 1, -1, "mid_run1");

    // AW=16, CW=8, DEPTH=8 instance
    do_reset("par");
    pdrive(3, 1'b0, 1'b0, 1'b1, 16'h1230);
    check("par_jmp y", p_y, 'h1230);
    pdrive(1, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    check("par_cjs y", p_y, 'hBEEF);
    check("par_cjs empty", p_empty, 1);
    pdrive(10, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("par_crtn y", p_y, 'h1231);
    check("par_crtn empty", p_empty, 0);
    pdrive(12, 1'b0, 1'b0, 1'b1, 16'h12A5);
    check("par_ldct empty", p_empty, 1);
    pdrive(7, 1'b0, 1'b1, 1'b1, 16'h0000);
    check("par_cnt y", p_y, 'h00A5);
    for (int k = 0; k < 8; k++) pdrive(4, 1'b0, 1'b1, 1'b1, 16'h0000);
    pdrive(14, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("par_full full_n", p_full_n, 0);
    check("par_full ovf", p_ovf, 0);
    pdrive(4, 1'b0, 1'b1, 1'b1, 16'h0000);
    pdrive(14, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("par_ovf ovf", p_ovf, 1);

    // random stimulus against the model
    do_reset("rnd");
    for (int k = 0; k < 600; k++) begin
      int op;
      op = int'($urandom_range(0, 15));
      if (op == 0 && $urandom_range(0, 3) != 0) op = 14;
      step(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), 12'($urandom),
           ($urandom_range(0, 9) == 0), -1, -1, -1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
